updown_counter_p: RTL

UPDOWN_COUNTER_P -- requirements
Module: updown_counter_p

---
 rtl/updown_counter_p.sv | 72 +++++++
 1 files changed

// File: rtl/updown_counter_p.sv
// Parameterised up/down counter with clamped parallel load, terminal-count
// detect, one-cycle bound pulse and sticky overflow/underflow flags.
// Define COUNTER_SATURATE_EN to hold at the bound instead of wrapping.
module updown_counter_p #(
  parameter int unsigned      WIDTH       = 8,
  parameter longint unsigned  MAX_COUNT   = 255,
  parameter longint unsigned  RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             upDown,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             clearFlags,
  output logic [WIDTH-1:0] countOut,
  output logic             terminalCount,
  output logic             boundPulse,
  output logic             overflowFlag,
  output logic             underflowFlag
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VALUE);

  logic             bound_event;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    terminalCount = upDown ? (countOut == MAX_V) : (countOut == '0);
  end

  // Load outranks enable, so a step masked by load is never a bound event.
  always_comb begin
    bound_event = enable & ~load & terminalCount;
  end

  always_comb begin
    load_clamped = (loadValue > MAX_V) ? MAX_V : loadValue;
    count_next   = countOut;
    if (load) begin
      count_next = load_clamped;
    end else if (enable) begin
      if (bound_event) begin
`ifdef COUNTER_SATURATE_EN
        count_next = countOut;
`else
        count_next = upDown ? '0 : MAX_V;
`endif
      end else begin
        count_next = upDown ? countOut + WIDTH'(1) : countOut - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      countOut      <= RESET_V;
      boundPulse    <= 1'b0;
      overflowFlag  <= 1'b0;
      underflowFlag <= 1'b0;
    end else begin
      countOut      <= count_next;
      boundPulse    <= bound_event;
      // A set in the same cycle as clearFlags wins.
      overflowFlag  <= (bound_event & upDown)  | (overflowFlag  & ~clearFlags);
      underflowFlag <= (bound_event & ~upDown) | (underflowFlag & ~clearFlags);
    end
  end

endmodule
